// File: rtl/ft245_pkg.sv
// Shared definitions for the FT245 bus arbiter: FSM state encoding, bus_dir codes
// and the default burst length.
package ft245_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX_OE,
    ST_RX_READ,
    ST_TX_WRITE,
    ST_TURN
  } state_t;

  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_RX   = 2'b01;
  localparam logic [1:0] DIR_TX   = 2'b10;
  localparam logic [1:0] DIR_TURN = 2'b11;

  localparam int DEFAULT_MAX_BURST = 64;

endpackage

// File: rtl/ft245_burst_counter.sv
// Saturating per-grant byte counter with synchronous clear and terminal flags.
module ft245_burst_counter
  import ft245_pkg::*;
#(
  parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic at_max,
  output logic near_max
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LIMIT    = CW'(MAX_BURST);
  localparam logic [CW-1:0] LIMIT_M1 = CW'(MAX_BURST - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + CW'(1);
    end
  end

  assign at_max   = (count == LIMIT);
  assign near_max = (count == LIMIT_M1);

endmodule

// File: rtl/ft245_bus_arbiter.sv
// FT245 synchronous-FIFO bus arbiter: time-shares the half-duplex FTDI bus between RX and TX.
// Define FT245_SIWU_EN to pulse ftdi_siwu low in TURN after a flushed TX burst drains.
module ft245_bus_arbiter
  import ft245_pkg::*;
#(
  parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ftdi_rde_n,
  input  logic       ftdi_txe_n,
  input  logic [7:0] ftdi_data_i,
  output logic [7:0] ftdi_data_o,
  output logic       ftdi_data_oe,
  output logic       ftdi_oe_n,
  output logic       ftdi_rd_n,
  output logic       ftdi_wr_n,
  output logic       ftdi_siwu,
  input  logic       rx_ready,
  output logic       rx_stb,
  output logic [7:0] rx_data,
  input  logic       tx_avail,
  input  logic [7:0] tx_data,
  output logic       tx_pop,
  input  logic       tx_flush,
  output logic [1:0] bus_dir
);

  state_t state;
  logic   last_tx;
  logic   at_max, near_max;
  logic   rx_req, tx_req;
  logic   rx_xfer, tx_xfer;
  logic   rx_last, tx_done;
  logic   flush_en;

`ifdef FT245_SIWU_EN
  assign flush_en = tx_flush;
`else
  assign flush_en = 1'b0;
  wire unused_flush = tx_flush;
`endif

  assign rx_req = !ftdi_rde_n && rx_ready;
  assign tx_req = !ftdi_txe_n && tx_avail;

  assign rx_xfer = (state == ST_RX_READ) && !ftdi_rd_n && !ftdi_rde_n;
  assign tx_xfer = (state == ST_TX_WRITE) && !ftdi_wr_n && !ftdi_txe_n;

  // In TX the staging register is full exactly when wr_n is low; the count tracks
  // popped bytes so the byte still in staging is already charged to this grant.
  assign tx_pop = (state == ST_TX_WRITE) && tx_avail && !at_max && (ftdi_wr_n || tx_xfer);

  assign rx_last = ftdi_rde_n || !rx_ready || at_max || (rx_xfer && near_max);
  assign tx_done = !tx_pop && (ftdi_wr_n || tx_xfer);

  ft245_burst_counter #(.MAX_BURST(MAX_BURST)) u_count (
    .clk      (clk),
    .rst      (rst),
    .clr      (state == ST_TURN),
    .inc      (rx_xfer || tx_pop),
    .at_max   (at_max),
    .near_max (near_max)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      last_tx      <= 1'b1;
      ftdi_oe_n    <= 1'b1;
      ftdi_rd_n    <= 1'b1;
      ftdi_wr_n    <= 1'b1;
      ftdi_siwu    <= 1'b1;
      ftdi_data_oe <= 1'b0;
      ftdi_data_o  <= 8'h00;
      rx_data      <= 8'h00;
      rx_stb       <= 1'b0;
      bus_dir      <= DIR_IDLE;
    end else begin
      rx_stb <= rx_xfer;
      if (rx_xfer) rx_data <= ftdi_data_i;
      if (tx_pop) ftdi_data_o <= tx_data;
      case (state)
        ST_IDLE: begin
          if (rx_req && (!tx_req || last_tx)) begin
            state     <= ST_RX_OE;
            ftdi_oe_n <= 1'b0;
            bus_dir   <= DIR_RX;
            last_tx   <= 1'b0;
          end else if (tx_req) begin
            state        <= ST_TX_WRITE;
            ftdi_data_oe <= 1'b1;
            bus_dir      <= DIR_TX;
            last_tx      <= 1'b1;
          end
        end
        ST_RX_OE: begin
          state     <= ST_RX_READ;
          ftdi_rd_n <= 1'b0;
        end
        ST_RX_READ: begin
          if (rx_last) begin
            state     <= ST_TURN;
            ftdi_oe_n <= 1'b1;
            ftdi_rd_n <= 1'b1;
            bus_dir   <= DIR_TURN;
          end
        end
        ST_TX_WRITE: begin
          ftdi_wr_n <= !(tx_pop || (!ftdi_wr_n && !tx_xfer));
          if (tx_done) begin
            state        <= ST_TURN;
            ftdi_data_oe <= 1'b0;
            bus_dir      <= DIR_TURN;
            if (flush_en && !tx_avail) ftdi_siwu <= 1'b0;
          end
        end
        ST_TURN: begin
          state     <= ST_IDLE;
          ftdi_siwu <= 1'b1;
          bus_dir   <= DIR_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ft245_bus_arbiter.sv
// Table-driven bench for ft245_bus_arbiter with FTDI/FIFO models and hand-written corner sequences.
module tb_ft245_bus_arbiter;

  localparam int MB = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0;
  logic       ftdi_rde_n, ftdi_txe_n;
  logic [7:0] ftdi_data_i, ftdi_data_o;
  logic       ftdi_data_oe, ftdi_oe_n, ftdi_rd_n, ftdi_wr_n, ftdi_siwu;
  logic       rx_ready, rx_stb, tx_avail, tx_pop, tx_flush;
  logic [7:0] rx_data, tx_data;
  logic [1:0] bus_dir;

  // stimulus controls (written only by the test process)
  int         rx_n = 0, tx_n = 0;
  logic       rx_rdy = 1'b1, txe_block = 1'b0, flush = 1'b0;
  logic [7:0] rx_src [512];
  logic [7:0] tx_src [512];

  // FIFO / pin model state (written only by the post-edge process)
  int         rd_idx, tx_idx, sink_n, xfer_total;
  logic [7:0] sink [512];

  // monitor state (written only by the negedge process)
  logic       c_pop, c_wr, c_rd;
  logic [7:0] c_wdata;
  int         cyc, rx_got_n, ng, nb, gap, burst_base, max_burst;
  int         overlap_err, lead_err, gap_err, siwu_low, siwu_bad, oe_cyc;
  logic [7:0] rx_got [512];
  int         bursts [16];
  logic [15:0] seq;
  logic [1:0] prev_dir;
  logic       prev_oe, prev_rd;

  int n_checks = 0, n_pass = 0;

  assign ftdi_rde_n  = !(rd_idx < rx_n);
  assign ftdi_data_i = rx_src[rd_idx[8:0]];
  assign ftdi_txe_n  = txe_block;
  assign tx_avail    = (tx_idx < tx_n);
  assign tx_data     = tx_src[tx_idx[8:0]];
  assign rx_ready    = rx_rdy;
  assign tx_flush    = flush;

  ft245_bus_arbiter #(.MAX_BURST(MB)) dut (
    .clk          (clk),
    .rst          (rst),
    .ftdi_rde_n   (ftdi_rde_n),
    .ftdi_txe_n   (ftdi_txe_n),
    .ftdi_data_i  (ftdi_data_i),
    .ftdi_data_o  (ftdi_data_o),
    .ftdi_data_oe (ftdi_data_oe),
    .ftdi_oe_n    (ftdi_oe_n),
    .ftdi_rd_n    (ftdi_rd_n),
    .ftdi_wr_n    (ftdi_wr_n),
    .ftdi_siwu    (ftdi_siwu),
    .rx_ready     (rx_ready),
    .rx_stb       (rx_stb),
    .rx_data      (rx_data),
    .tx_avail     (tx_avail),
    .tx_data      (tx_data),
    .tx_pop       (tx_pop),
    .tx_flush     (tx_flush),
    .bus_dir      (bus_dir)
  );

  // Mid-cycle: capture what the next rising edge will see, and watch protocol properties.
  always @(negedge clk) begin
    c_pop   = tx_pop;
    c_wr    = !ftdi_wr_n && !ftdi_txe_n;
    c_wdata = ftdi_data_o;
    c_rd    = !ftdi_rd_n && !ftdi_rde_n;
    if (!rst) begin
      rx_got_n = 0; ng = 0; nb = 0; gap = 0; burst_base = 0; max_burst = 0;
      overlap_err = 0; lead_err = 0; gap_err = 0; siwu_low = 0; siwu_bad = 0;
      oe_cyc = 0; seq = '0; prev_dir = 2'b00; prev_oe = 1'b1; prev_rd = 1'b1;
    end else begin
      cyc++;
      if (rx_stb) begin
        rx_got[rx_got_n[8:0]] = rx_data;
        rx_got_n++;
      end
      if (ftdi_data_oe && !ftdi_oe_n) overlap_err++;
      if (!ftdi_siwu) begin
        siwu_low++;
        if (bus_dir != 2'b11) siwu_bad++;
      end
      if (prev_oe && !ftdi_oe_n) oe_cyc = cyc;
      if (prev_rd && !ftdi_rd_n && (cyc - oe_cyc != 1)) lead_err++;
      if (!prev_oe && ftdi_oe_n && !ftdi_rd_n) lead_err++;
      if (prev_dir == 2'b00 && (bus_dir == 2'b01 || bus_dir == 2'b10)) begin
        if (ng > 0 && gap < 2) gap_err++;
        seq[ng[3:0]] = bus_dir[1];
        ng++;
        gap = 0;
        burst_base = xfer_total;
      end else if (bus_dir == 2'b00 || bus_dir == 2'b11) begin
        gap++;
      end
      if (bus_dir == 2'b11 && prev_dir != 2'b11) begin
        bursts[nb[3:0]] = xfer_total - burst_base;
        if (xfer_total - burst_base > max_burst) max_burst = xfer_total - burst_base;
        nb++;
      end
      prev_dir = bus_dir;
      prev_oe  = ftdi_oe_n;
      prev_rd  = ftdi_rd_n;
    end
  end

  // Just after the edge: FTDI chip and TX FIFO react to what happened on it.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      rd_idx = 0; tx_idx = 0; sink_n = 0; xfer_total = 0;
    end else begin
      if (c_pop) tx_idx++;
      if (c_rd) begin
        rd_idx++;
        xfer_total++;
      end
      if (c_wr) begin
        sink[sink_n[8:0]] = c_wdata;
        sink_n++;
        xfer_total++;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic start(input int nrx, input int ntx, input logic rdy);
    rst = 1'b0;
    rx_n = nrx; tx_n = ntx; rx_rdy = rdy; txe_block = 1'b0;
    repeat (2) step();
    rst = 1'b1;
  endtask

  task automatic run_done(input string name, input int budget);
    int k = 0;
    while (!((rx_rdy == 1'b0 || rd_idx == rx_n) && tx_idx == tx_n && sink_n == tx_n &&
             bus_dir == 2'b00) && k < budget) begin
      step();
      k++;
    end
    chk({name, " finished in budget"}, int'(k < budget), 1);
    repeat (3) step();
  endtask

  function automatic int rx_errs();
    int e = 0;
    for (int j = 0; j < rx_got_n && j < 512; j++) if (rx_got[j] != rx_src[j]) e++;
    return e;
  endfunction

  function automatic int tx_errs();
    int e = 0;
    for (int j = 0; j < sink_n && j < 512; j++) if (sink[j] != tx_src[j]) e++;
    return e;
  endfunction

  typedef struct {
    int         nrx;
    int         ntx;
    logic       rdy;
    int         exp_rx;
    int         exp_tx;
    int         exp_ng;
    logic [7:0] exp_seq;
    int         exp_first;
    int         exp_last;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int first, last, r0, exp_low, hold_err;
    logic [7:0] held;

    vecs[0] = '{5,   0,   1'b1, 5,   0,   1, 8'h00, 5,  5};
    vecs[1] = '{0,   300, 1'b1, 0,   300, 5, 8'h1F, 64, 44};
    vecs[2] = '{100, 100, 1'b1, 100, 100, 4, 8'h0A, 64, 36};
    vecs[3] = '{0,   0,   1'b1, 0,   0,   0, 8'h00, 0,  0};
    vecs[4] = '{3,   0,   1'b0, 0,   0,   0, 8'h00, 0,  0};
    vecs[5] = '{1,   1,   1'b1, 1,   1,   2, 8'h02, 1,  1};
    vecs[6] = '{65,  0,   1'b1, 65,  0,   2, 8'h00, 64, 1};

    for (int i = 0; i < 512; i++) begin
      rx_src[i] = 8'(8'h11 + i);
      tx_src[i] = 8'(i * 7 + 3);
    end

    // reset values
    step();
    step();
    chk("reset oe_n", int'(ftdi_oe_n), 1);
    chk("reset rd_n", int'(ftdi_rd_n), 1);
    chk("reset wr_n", int'(ftdi_wr_n), 1);
    chk("reset siwu", int'(ftdi_siwu), 1);
    chk("reset data_oe", int'(ftdi_data_oe), 0);
    chk("reset data_o", int'(ftdi_data_o), 0);
    chk("reset rx_data", int'(rx_data), 0);
    chk("reset rx_stb", int'(rx_stb), 0);
    chk("reset tx_pop", int'(tx_pop), 0);
    chk("reset bus_dir", int'(bus_dir), 0);

    for (int i = 0; i < 7; i++) begin
      start(vecs[i].nrx, vecs[i].ntx, vecs[i].rdy);
      run_done($sformatf("v%0d", i), 3000);
      first = (nb > 0) ? bursts[0] : 0;
      last  = (nb > 0) ? bursts[(nb - 1) & 15] : 0;
      chk($sformatf("v%0d rx bytes", i), rx_got_n, vecs[i].exp_rx);
      chk($sformatf("v%0d tx bytes", i), sink_n, vecs[i].exp_tx);
      chk($sformatf("v%0d rx data errors", i), rx_errs(), 0);
      chk($sformatf("v%0d tx data errors", i), tx_errs(), 0);
      chk($sformatf("v%0d grants", i), ng, vecs[i].exp_ng);
      chk($sformatf("v%0d grant order", i), int'(seq[7:0]), int'(vecs[i].exp_seq));
      chk($sformatf("v%0d first burst", i), first, vecs[i].exp_first);
      chk($sformatf("v%0d last burst", i), last, vecs[i].exp_last);
      chk($sformatf("v%0d burst within max", i), int'(max_burst <= MB), 1);
      chk($sformatf("v%0d oe/data_oe overlap", i), overlap_err, 0);
      chk($sformatf("v%0d oe leads rd", i), lead_err, 0);
      chk($sformatf("v%0d turnaround gap", i), gap_err, 0);
      chk($sformatf("v%0d bus_dir idle", i), int'(bus_dir), 0);
    end

    // TX stalled by txe_n for three edges: byte and wr_n hold, then it goes out once
    start(0, 10, 1'b1);
    r0 = 0;
    while (sink_n < 4 && r0 < 100) begin
      step();
      r0++;
    end
    chk("stall reached", int'(sink_n == 4), 1);
    txe_block = 1'b1;
    held = tx_src[4];
    hold_err = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (ftdi_wr_n !== 1'b0 || ftdi_data_o !== held || tx_pop !== 1'b0) hold_err++;
    end
    @(posedge clk);
    #2;
    chk("stall bytes frozen", sink_n, 4);
    txe_block = 1'b0;
    chk("stall hold errors", hold_err, 0);
    run_done("stall", 500);
    chk("stall tx bytes", sink_n, 10);
    chk("stall tx data errors", tx_errs(), 0);

    // rx_ready drops mid-burst
    start(20, 0, 1'b1);
    r0 = 0;
    while (rd_idx < 3 && r0 < 100) begin
      step();
      r0++;
    end
    r0 = rd_idx;
    rx_rdy = 1'b0;
    repeat (8) step();
    chk("rxdrop extra bytes <=1", int'(rd_idx - r0 <= 1), 1);
    chk("rxdrop strobes match pins", rx_got_n, rd_idx);
    chk("rxdrop rd_n high", int'(ftdi_rd_n), 1);
    chk("rxdrop bus idle", int'(bus_dir), 0);
    chk("rxdrop one turn", nb, 1);
    rx_rdy = 1'b1;
    run_done("rxdrop", 500);
    chk("rxdrop rx bytes", rx_got_n, 20);
    chk("rxdrop rx data errors", rx_errs(), 0);

    // flush request at the end of a short TX burst
    flush = 1'b1;
    start(0, 3, 1'b1);
    run_done("siwu", 200);
    flush = 1'b0;
`ifdef FT245_SIWU_EN
    exp_low = 1;
`else
    exp_low = 0;
`endif
    chk("siwu low cycles", siwu_low, exp_low);
    chk("siwu low outside TURN", siwu_bad, 0);
    chk("siwu tx bytes", sink_n, 3);

    // asynchronous reset in the middle of a TX burst
    start(0, 100, 1'b1);
    r0 = 0;
    while (sink_n < 10 && r0 < 100) begin
      step();
      r0++;
    end
    #1;
    rst = 1'b0;
    #1;
    chk("async rst wr_n", int'(ftdi_wr_n), 1);
    chk("async rst data_oe", int'(ftdi_data_oe), 0);
    chk("async rst data_o", int'(ftdi_data_o), 0);
    chk("async rst bus_dir", int'(bus_dir), 0);
    chk("async rst tx_pop", int'(tx_pop), 0);
    chk("async rst oe_n/rd_n/siwu", int'({ftdi_oe_n, ftdi_rd_n, ftdi_siwu}), 7);
    start(0, 2, 1'b1);
    chk("post-rst bus_dir", int'(bus_dir), 0);
    run_done("post-rst", 200);
    chk("post-rst tx bytes", sink_n, 2);
    chk("post-rst tx data errors", tx_errs(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
